dm_rmw_ctrl: RTL and testbench

//  Sequences MEM-stage data-memory accesses onto a word-only, single-port synchronous RAM.

---
 rtl/dm_pkg.sv | 32 +++
 rtl/dm_byte_merge.sv | 13 +
 rtl/dm_rmw_ctrl.sv | 122 ++++++++++++
 tb/tb_dm_rmw_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory read-modify-write controller:
// state codes, byte-enable patterns and the store byte-enable legality check.
package dm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_LD   = 3'd3,
    ST_MG   = 3'd4,
    ST_ERR  = 3'd5
  } dm_state_t;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_BYTE1   = 4'b0010;
  localparam logic [3:0] BE_BYTE2   = 4'b0100;
  localparam logic [3:0] BE_BYTE3   = 4'b1000;

  function automatic logic be_legal(input logic [3:0] be);
    logic ok;
    case (be)
      BE_WORD, BE_HALF_LO, BE_HALF_HI,
      BE_BYTE0, BE_BYTE1, BE_BYTE2, BE_BYTE3: ok = 1'b1;
      default:                                ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dm_byte_merge.sv
// Per-lane byte merge: enabled lanes take the new data, the rest keep the old word.
module dm_byte_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  be,
  output logic [31:0] merged
);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign merged[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
  end

endmodule

// File: rtl/dm_rmw_ctrl.sv
// MEM-stage data-memory sequencer for a word-only single-port synchronous RAM.
// Sub-word stores run as read-then-merge-write; the pipeline is stalled meanwhile.
module dm_rmw_ctrl
  import dm_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [3:0]        cpu_be,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_stall,
  output logic              cpu_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  dm_state_t         state, state_nxt;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [3:0]        req_be;
  logic [31:0]       req_wdata;
  logic [3:0]        be_norm;
  logic [31:0]       merged;
  logic              unused_addr;

  // Byte offset bits and bits above the RAM range never reach the RAM.
  assign unused_addr = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};

  assign be_norm = (cpu_be == 4'b0000) ? BE_WORD : cpu_be;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_be    <= '0;
      req_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && cpu_req) begin
        req_we    <= cpu_we;
        req_addr  <= cpu_addr[ADDR_W+1:2];
        req_be    <= be_norm;
        req_wdata <= cpu_wdata;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (cpu_req) begin
          if (!cpu_we)                state_nxt = ST_RD;
          else if (be_norm == BE_WORD) state_nxt = ST_WR;
          else if (be_legal(be_norm))  state_nxt = ST_RD;
          else                         state_nxt = ST_ERR;
        end
      end
      ST_RD:   state_nxt = req_we ? ST_MG : ST_LD;
      ST_WR,
      ST_LD,
      ST_MG,
      ST_ERR:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  dm_byte_merge u_merge (
    .old_word (ram_rdata),
    .new_word (req_wdata),
    .be       (req_be),
    .merged   (merged)
  );

  always_comb begin
    cpu_rdata = '0;
    cpu_done  = 1'b0;
    cpu_err   = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    ram_addr  = (state == ST_IDLE) ? '0 : req_addr;
    case (state)
      ST_WR: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_wdata = req_wdata;
        cpu_done  = 1'b1;
      end
      ST_RD: ram_en = 1'b1;
      ST_LD: begin
        cpu_rdata = ram_rdata;
        cpu_done  = 1'b1;
      end
      ST_MG: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_wdata = merged;
        cpu_done  = 1'b1;
      end
      ST_ERR: begin
        cpu_done = 1'b1;
        cpu_err  = 1'b1;
      end
      default: ;
    endcase
  end

  // Gated by reset so the pipeline sees no stall while the controller is held.
  assign cpu_stall = cpu_req & ~cpu_done & ~reset;

endmodule

// File: tb/tb_dm_rmw_ctrl.sv
// Self-checking bench for dm_rmw_ctrl: directed vector table, reset corner
// sequences and randomized traffic against a word-array reference model.
module tb_dm_rmw_ctrl;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_req, cpu_we;
  logic [31:0]       cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]        cpu_be;
  logic              cpu_done, cpu_stall, cpu_err;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata, ram_rdata;

  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic [31:0]       ref_mem [0:15];
  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [31:0]       pl_data = '0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dm_rmw_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_be(cpu_be),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .cpu_stall(cpu_stall), .cpu_err(cpu_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Single-port synchronous RAM; the preload port lets the bench seed contents.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata, output int lat, output logic [31:0] rd,
                         output logic err, output bit wr_seen, output logic [ADDR_W-1:0] waddr,
                         output logic [31:0] wdat, output bit en_seen, output logic stall0,
                         output logic [ADDR_W-1:0] idle_addr);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_be = be; cpu_wdata = wdata;
    #1;
    stall0 = cpu_stall; idle_addr = ram_addr;
    lat = 0; rd = '0; err = 1'b0; wr_seen = 0; en_seen = 0; waddr = '0; wdat = '0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (ram_en) en_seen = 1;
      if (ram_en && ram_we) begin
        wr_seen = 1; waddr = ram_addr; wdat = ram_wdata;
      end
      if (cpu_done) begin
        lat = c; rd = cpu_rdata; err = cpu_err;
        break;
      end
    end
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_be = '0; cpu_wdata = '0;
  endtask

  typedef struct {
    string             name;
    bit                we;
    logic [31:0]       addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic [ADDR_W-1:0] pl_addr;
    logic [31:0]       pl_val;
    int                lat;
    logic [31:0]       rdata;
    bit                err;
    bit                wr;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdat;
    bit                en;
  } vec_t;

  function automatic vec_t mk(string name, bit we, logic [31:0] addr, logic [3:0] be,
                              logic [31:0] wdata, logic [ADDR_W-1:0] pa, logic [31:0] pv,
                              int lat, logic [31:0] rdata, bit err, bit wr,
                              logic [ADDR_W-1:0] waddr, logic [31:0] wdat, bit en);
    vec_t v;
    v.name = name; v.we = we; v.addr = addr; v.be = be; v.wdata = wdata;
    v.pl_addr = pa; v.pl_val = pv; v.lat = lat; v.rdata = rdata; v.err = err;
    v.wr = wr; v.waddr = waddr; v.wdat = wdat; v.en = en;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    int lat;
    logic [31:0] rd, wdat;
    logic err, stall0;
    bit wr_seen, en_seen;
    logic [ADDR_W-1:0] waddr, idle_addr;

    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_be = 4'hF; cpu_wdata = 32'h1;
    for (int i = 0; i < 16; i++) preload(ADDR_W'(i), 32'h0);
    #1;
    check("reset_ram_en",    {31'b0, ram_en},    32'h0);
    check("reset_ram_we",    {31'b0, ram_we},    32'h0);
    check("reset_ram_addr",  32'(ram_addr),      32'h0);
    check("reset_ram_wdata", ram_wdata,          32'h0);
    check("reset_done",      {31'b0, cpu_done},  32'h0);
    check("reset_err",       {31'b0, cpu_err},   32'h0);
    check("reset_stall",     {31'b0, cpu_stall}, 32'h0);
    check("reset_rdata",     cpu_rdata,          32'h0);
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_be = '0; cpu_wdata = '0;
    reset = 1'b0;

    vecs.push_back(mk("sw_word",   1, 32'h10, 4'b1111, 32'hDEADBEEF, 4, 32'h0,      1, 0, 0, 1, 4, 32'hDEADBEEF, 1));
    vecs.push_back(mk("sb_lane2",  1, 32'h10, 4'b0100, 32'h00AA0000, 4, 32'h11223344, 2, 0, 0, 1, 4, 32'h11AA3344, 1));
    vecs.push_back(mk("sh_high",   1, 32'h10, 4'b1100, 32'hBEEF0000, 4, 32'h11223344, 2, 0, 0, 1, 4, 32'hBEEF3344, 1));
    vecs.push_back(mk("load",      0, 32'h1C, 4'b1111, 32'h0,        7, 32'hCAFEF00D, 2, 32'hCAFEF00D, 0, 0, 0, 0, 1));
    vecs.push_back(mk("ill_be",    1, 32'h10, 4'b0101, 32'h12345678, 4, 32'h11223344, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("be0_word",  1, 32'h20, 4'b0000, 32'h12345678, 8, 32'hFFFFFFFF, 1, 0, 0, 1, 8, 32'h12345678, 1));
    vecs.push_back(mk("sh_lo_off", 1, 32'h26, 4'b0011, 32'h00001122, 9, 32'hAABBCCDD, 2, 0, 0, 1, 9, 32'hAABB1122, 1));
    vecs.push_back(mk("sb_lane0",  1, 32'h24, 4'b0001, 32'h000000EE, 9, 32'hAABBCCDD, 2, 0, 0, 1, 9, 32'hAABBCCEE, 1));
    vecs.push_back(mk("sb_lane3",  1, 32'h24, 4'b1000, 32'h77000000, 9, 32'hAABBCCDD, 2, 0, 0, 1, 9, 32'h77BBCCDD, 1));
    vecs.push_back(mk("ld_ign_be", 0, 32'h1F, 4'b0101, 32'h0,        7, 32'h0BADF00D, 2, 32'h0BADF00D, 0, 0, 0, 0, 1));
    vecs.push_back(mk("ill_be_9",  1, 32'h10, 4'b1001, 32'h12345678, 4, 32'h11223344, 1, 0, 1, 0, 0, 0, 0));

    foreach (vecs[k]) begin
      preload(vecs[k].pl_addr, vecs[k].pl_val);
      run_txn(vecs[k].we, vecs[k].addr, vecs[k].be, vecs[k].wdata,
              lat, rd, err, wr_seen, waddr, wdat, en_seen, stall0, idle_addr);
      check({vecs[k].name, "_lat"},    32'(lat),           32'(vecs[k].lat));
      check({vecs[k].name, "_err"},    {31'b0, err},       {31'b0, vecs[k].err});
      check({vecs[k].name, "_rdata"},  rd,                 vecs[k].rdata);
      check({vecs[k].name, "_wr"},     {31'b0, wr_seen},   {31'b0, vecs[k].wr});
      check({vecs[k].name, "_en"},     {31'b0, en_seen},   {31'b0, vecs[k].en});
      check({vecs[k].name, "_stall0"}, {31'b0, stall0},    32'h1);
      check({vecs[k].name, "_idleadr"}, 32'(idle_addr),    32'h0);
      if (vecs[k].wr) begin
        check({vecs[k].name, "_waddr"}, 32'(waddr), 32'(vecs[k].waddr));
        check({vecs[k].name, "_wdata"}, wdat,       vecs[k].wdat);
      end
    end

    // Reset while a byte store is in its read phase.
    preload(5, 32'h55667788);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h14; cpu_be = 4'b0010; cpu_wdata = 32'h0000AB00;
    @(negedge clk);
    check("rd_phase_en", {31'b0, ram_en}, 32'h1);
    check("rd_phase_we", {31'b0, ram_we}, 32'h0);
    reset = 1'b1;
    #1;
    check("rst_rd_en",   {31'b0, ram_en},   32'h0);
    check("rst_rd_addr", 32'(ram_addr),     32'h0);
    check("rst_rd_done", {31'b0, cpu_done}, 32'h0);
    cpu_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rd_mem", mem[5], 32'h55667788);
    run_txn(1'b1, 32'h14, 4'b0010, 32'h0000AB00, lat, rd, err, wr_seen, waddr, wdat, en_seen, stall0, idle_addr);
    check("post_rst_lat",   32'(lat), 32'd2);
    check("post_rst_wdata", wdat,     32'h5566AB88);
    @(posedge clk); #1;
    check("post_rst_mem",   mem[5],   32'h5566AB88);

    // Reset while the merge write is on the RAM port: the write must not land.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h14; cpu_be = 4'b0011; cpu_wdata = 32'h0000CDEF;
    repeat (2) @(negedge clk);
    check("mg_phase_we", {31'b0, ram_we}, 32'h1);
    reset = 1'b1;
    #1;
    check("rst_mg_we",   {31'b0, ram_we},   32'h0);
    check("rst_mg_done", {31'b0, cpu_done}, 32'h0);
    cpu_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_mg_mem", mem[5], 32'h5566AB88);

    // Randomized traffic against the reference word array.
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      preload(ADDR_W'(i), ref_mem[i]);
    end
    for (int t = 0; t < 300; t++) begin
      logic        r_we;
      logic [3:0]  r_be, beff;
      logic [31:0] r_wd, r_addr, nw;
      int          w, e_lat;
      logic [31:0] e_rd;
      bit          e_err, legal;
      r_we   = 1'($urandom_range(0, 1));
      w      = $urandom_range(0, 15);
      r_addr = (w * 4) + $urandom_range(0, 3);
      r_be   = 4'($urandom_range(0, 15));
      r_wd   = $urandom;
      beff   = (r_be == 4'b0000) ? 4'b1111 : r_be;
      legal  = (beff == 4'b1111) || (beff == 4'b0011) || (beff == 4'b1100) || ($countones(beff) == 1);
      e_rd = 32'h0; e_err = 0;
      if (!r_we) begin
        e_lat = 2; e_rd = ref_mem[w];
      end else if (!legal) begin
        e_lat = 1; e_err = 1;
      end else begin
        e_lat = (beff == 4'b1111) ? 1 : 2;
        nw = ref_mem[w];
        for (int b = 0; b < 4; b++)
          if (beff[b]) nw = (nw & ~(32'hFF << (8*b))) | (r_wd & (32'hFF << (8*b)));
        ref_mem[w] = nw;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_txn(r_we, r_addr, r_be, r_wd, lat, rd, err, wr_seen, waddr, wdat, en_seen, stall0, idle_addr);
      check($sformatf("rnd%0d_lat", t),   32'(lat),     32'(e_lat));
      check($sformatf("rnd%0d_err", t),   {31'b0, err}, {31'b0, e_err});
      check($sformatf("rnd%0d_rdata", t), rd,           e_rd);
      if (wr_seen) check($sformatf("rnd%0d_waddr", t), 32'(waddr), 32'(w));
    end
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) check($sformatf("mem_final_%0d", i), mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
